mem_port_arbiter: RTL and testbench

- Shares one single-outstanding memory bus port between the IF-stage instruction fetch and the MEM-stage data access.
- Sequences both requests of one pipeline step: data first, then instruction. Registers the read data.
- Drives mem_stall, which holds all pipeline stages frozen until both accesses of the step have completed.
- Sits between the pipeline datapath and the external bus/cache bridge.

---
 rtl/arb_pkg.sv | 12 +
 rtl/arb_fetch_buf.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding and default widths.
package arb_pkg;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_D_ADDR = 3'd1;
  localparam logic [2:0] ST_D_WAIT = 3'd2;
  localparam logic [2:0] ST_I_ADDR = 3'd3;
  localparam logic [2:0] ST_I_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
endpackage

// File: rtl/arb_fetch_buf.sv
// One-entry instruction fetch buffer {valid, tag, word}. Filled by every bus
// fetch, invalidated by a store to the buffered word. Only built when
// ARB_INST_BUF_EN is defined.
module arb_fetch_buf import arb_pkg::*; #(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] i_lookup_addr,  // current fetch address, also the fill tag
  input  logic [ADDR_W-1:2] i_st_addr,      // store word address
  input  logic              i_st_clr,       // a store is completing this cycle
  input  logic              i_fill,
  input  logic [DATA_W-1:0] i_fill_word,
  output logic              o_hit,
  output logic              o_st_match,
  output logic [DATA_W-1:0] o_word
);
  logic              r_valid;
  logic [ADDR_W-1:0] r_tag;
  logic [DATA_W-1:0] r_word;

  assign o_hit      = r_valid && (r_tag == i_lookup_addr);
  assign o_st_match = r_valid && (r_tag[ADDR_W-1:2] == i_st_addr);
  assign o_word     = r_word;

  // Fill on a bus fetch capture; drop the entry when a store overwrites it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_word  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_lookup_addr;
      r_word  <= i_fill_word;
    end else if (i_st_clr && o_st_match) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding bus port between instruction fetch and data
// access. Within one pipeline step the data access goes first, then the fetch;
// mem_stall freezes the pipeline until both have completed.
// Optional fetch buffer: define ARB_INST_BUF_EN.
module mem_port_arbiter import arb_pkg::*; #(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);
  logic [2:0]        r_state, w_next;
  logic              r_pend_inst;
  logic              w_hit;      // inst-only step served from the buffer
  logic              w_d_hit;    // fetch after a data access served from the buffer
  logic [DATA_W-1:0] w_buf_word;
  logic              w_d_done, w_i_done;

  assign w_d_done = (r_state == ST_D_WAIT) && bus_data_ok;
  assign w_i_done = (r_state == ST_I_WAIT) && bus_data_ok;

`ifdef ARB_INST_BUF_EN
  logic w_buf_hit, w_st_match;
  arb_fetch_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fetch_buf (
    .clk          (clk),
    .resetn       (resetn),
    .i_lookup_addr(inst_addr),
    .i_st_addr    (data_addr[ADDR_W-1:2]),
    .i_st_clr     (w_d_done && data_wr),
    .i_fill       (w_i_done),
    .i_fill_word  (bus_rdata),
    .o_hit        (w_buf_hit),
    .o_st_match   (w_st_match),
    .o_word       (w_buf_word)
  );
  assign w_hit   = w_buf_hit;
  // A store clobbering the buffered word in this same step must not hit.
  assign w_d_hit = w_buf_hit && !(data_wr && w_st_match);
`else
  assign w_hit      = 1'b0;
  assign w_d_hit    = 1'b0;
  assign w_buf_word = '0;
`endif

  assign mem_stall = (r_state != ST_IDLE && r_state != ST_DONE) ||
                     (r_state == ST_IDLE && (inst_req || data_req));

  // Next-state: data access first, then fetch; addr_ok wins over a same-cycle data_ok.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (data_req)         w_next = ST_D_ADDR;
                 else if (inst_req)    w_next = w_hit ? ST_DONE : ST_I_ADDR;
      ST_D_ADDR: if (bus_addr_ok)      w_next = ST_D_WAIT;
      ST_D_WAIT: if (bus_data_ok)      w_next = (r_pend_inst && !w_d_hit) ? ST_I_ADDR : ST_DONE;
      ST_I_ADDR: if (bus_addr_ok)      w_next = ST_I_WAIT;
      ST_I_WAIT: if (bus_data_ok)      w_next = ST_DONE;
      default:                         w_next = ST_IDLE;
    endcase
  end

  // Bus address phase driven straight from the state and the held request inputs.
  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
    case (r_state)
      ST_D_ADDR: begin
        bus_req   = 1'b1;
        bus_wr    = data_wr;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
        bus_wstrb = data_wr ? data_wstrb : '1;
      end
      ST_I_ADDR: begin
        bus_req   = 1'b1;
        bus_addr  = inst_addr;
        bus_wstrb = '1;
      end
      default: ;
    endcase
  end

  // State, pending-fetch flag and registered read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_pend_inst <= 1'b0;
      inst_rdata  <= '0;
      data_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && data_req) r_pend_inst <= inst_req;
      if (w_d_done && !data_wr) data_rdata <= bus_rdata;
      if (w_i_done)
        inst_rdata <= bus_rdata;
      else if ((r_state == ST_IDLE && !data_req && inst_req && w_hit) ||
               (w_d_done && r_pend_inst && w_d_hit))
        inst_rdata <= w_buf_word;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. The bench plays the bus slave with
// random handshake delays and predicts, per pipeline step, the ordered list of
// bus transactions, the stall length and the captured read data.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_stall, bus_req, bus_wr;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int n_chk = 0, n_fail = 0;

  // model state
  logic [31:0] m_irdata = 0, m_drdata = 0;
  bit          m_bv = 0;
  logic [31:0] m_btag = 0, m_bword = 0;

  mem_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .inst_rdata(inst_rdata), .data_rdata(data_rdata), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [68:0] key(input logic wr, input logic [31:0] a,
                                      input logic [31:0] w, input logic [3:0] s);
    return {wr, a, (wr ? w : 32'h0), s};
  endfunction

  // One pipeline step. Called at a point away from the rising edge.
  task automatic do_step(input bit dreq, input bit dwr, input bit ireq,
                         input logic [31:0] daddr, input logic [31:0] iaddr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] drd, input logic [31:0] ird,
                         input int ad0, input int dd0, input int ad1, input int dd1,
                         input bit same);
    logic [68:0] ex[$];
    logic [31:0] rd[$];
    int          ad[$], dd[$];
    int          exp_stall, tx, acnt, dcnt, stall;
    bit          ihit, clob, in_data, done;
    ihit = 0; clob = 0;
`ifdef ARB_INST_BUF_EN
    clob = dreq && dwr && m_bv && (daddr[31:2] == m_btag[31:2]);
    ihit = ireq && m_bv && (m_btag == iaddr) && !clob;
`endif
    exp_stall = 1;
    if (dreq) begin
      ex.push_back(key(dwr, daddr, wdata, dwr ? wstrb : 4'hF));
      rd.push_back(drd); ad.push_back(ad0); dd.push_back(dd0);
      exp_stall += ad0 + dd0 + 2;
    end
    if (ireq && !ihit) begin
      ex.push_back(key(1'b0, iaddr, 32'h0, 4'hF));
      rd.push_back(ird); ad.push_back(dreq ? ad1 : ad0); dd.push_back(dreq ? dd1 : dd0);
      exp_stall += (dreq ? ad1 + dd1 : ad0 + dd0) + 2;
    end
    if (dreq && !dwr) m_drdata = drd;
    if (ireq) m_irdata = ihit ? m_bword : ird;
    if (clob) m_bv = 0;
    if (ireq && !ihit) begin m_bv = 1; m_btag = iaddr; m_bword = ird; end

    data_req = dreq; data_wr = dwr; inst_req = ireq;
    data_addr = daddr; inst_addr = iaddr; data_wdata = wdata; data_wstrb = wstrb;
    tx = 0; acnt = 0; dcnt = 0; stall = 0; in_data = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (!mem_stall) done = 1;
      else begin
        stall++;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = $urandom;
        if (in_data) begin
          chk("req_low_in_wait", bus_req, 0);
          if (dcnt == dd[tx]) begin
            bus_data_ok = 1; bus_rdata = rd[tx]; in_data = 0; tx++;
          end else dcnt++;
        end else if (bus_req) begin
          if (tx < ex.size()) begin
            chk("bus_fields", key(bus_wr, bus_addr, bus_wdata, bus_wstrb), ex[tx]);
            if (acnt == ad[tx]) begin
              bus_addr_ok = 1; in_data = 1; dcnt = 0; acnt = 0;
              if (same && tx == 0) begin bus_data_ok = 1; bus_rdata = ~rd[0]; end
            end else acnt++;
          end else chk("extra_bus_req", 1, 0);
        end else if (c == 0 && $urandom_range(3) == 0) begin
          bus_data_ok = 1;   // stray data_ok while idle must be ignored
        end
        @(negedge clk);
      end
    end
    chk("step_timeout", done, 1);
    chk("stall_cycles", stall, exp_stall);
    chk("tx_count", tx, ex.size());
    chk("inst_rdata", inst_rdata, m_irdata);
    chk("data_rdata", data_rdata, m_drdata);
    chk("done_no_req", bus_req, 0);
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
    @(negedge clk);
    #1 chk("idle_no_stall", mem_stall, 0);
  endtask

  task automatic rand_step();
    bit dreq, ireq, dwr;
    logic [31:0] ia, da;
    dreq = $urandom_range(1); ireq = $urandom_range(1);
    if (!dreq && !ireq) ireq = 1;
    dwr = $urandom_range(1);
    ia = 32'hBFC0_0000 + 4 * $urandom_range(3);
    da = $urandom_range(1) ? (32'hBFC0_0000 + 4 * $urandom_range(3) + $urandom_range(3))
                           : (32'h8000_0000 | ($urandom & 32'hFFFC));
    do_step(dreq, dwr, ireq, da, ia, $urandom, 4'($urandom), $urandom, $urandom,
            $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3),
            dreq && $urandom_range(1));
  endtask

  initial begin
    resetn = 0; inst_req = 0; data_req = 0; data_wr = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    #2;
    chk("rst_stall", mem_stall, 0);
    chk("rst_bus", {bus_req, bus_wr, bus_addr, bus_wdata, bus_wstrb}, 0);
    chk("rst_rdata", {inst_rdata, data_rdata}, 0);
    @(negedge clk); resetn = 1;
    @(negedge clk); #1;

    // directed steps
    do_step(0, 0, 1, 32'h0, 32'hBFC0_0000, 0, 0, 0, 32'h2408_0001, 0, 0, 0, 0, 0);
    do_step(1, 0, 1, 32'h8000_1000, 32'hBFC0_0004, 0, 0, 32'h1234_5678, 32'h0000_0013,
            0, 0, 0, 0, 0);
    do_step(1, 1, 0, 32'h8000_2000, 0, 32'hDEAD_BEEF, 4'b0011, 0, 0, 3, 0, 0, 0, 0);
    do_step(1, 0, 0, 32'h8000_3000, 0, 0, 0, 32'hCAFE_F00D, 0, 0, 1, 0, 0, 1);
    do_step(0, 0, 1, 0, 32'hBFC0_0000, 0, 0, 0, 32'h2408_0001, 0, 0, 0, 0, 0);
    do_step(0, 0, 1, 0, 32'hBFC0_0000, 0, 0, 0, 32'h2408_0001, 0, 0, 0, 0, 0);
    do_step(1, 1, 0, 32'hBFC0_0000, 0, 32'h1111_2222, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    do_step(0, 0, 1, 0, 32'hBFC0_0000, 0, 0, 0, 32'h3C1C_0000, 1, 2, 0, 0, 0);

    for (int i = 0; i < 80; i++) rand_step();

    // reset while a load sits in D_WAIT
    data_req = 1; data_wr = 0; data_addr = 32'h8000_4000;
    @(negedge clk); bus_addr_ok = 1;
    @(negedge clk); bus_addr_ok = 0;
    #1 resetn = 0; data_req = 0;
    #1;
    chk("midrst_stall", mem_stall, 0);
    chk("midrst_bus", {bus_req, bus_wr, bus_addr, bus_wdata, bus_wstrb}, 0);
    chk("midrst_rdata", {inst_rdata, data_rdata}, 0);
    m_irdata = 0; m_drdata = 0; m_bv = 0;
    @(negedge clk); resetn = 1;
    @(negedge clk); #1;

    for (int i = 0; i < 10; i++) rand_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
